// File: rtl/lsu_hs.sv
// Purpose: handshaked load/store unit; checks alignment, issues one backend access, returns an extended load result or a store completion.
// Latency: 3 cycles minimum from request acceptance to resp_valid (backend ready at once, response one cycle after its handshake); 1 cycle for alignment/size errors.
// Backpressure: one access in flight; req_ready only in IDLE, mem_* held until mem_req_ready, resp_* held until resp_ready.
module lsu_hs #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  // core request channel
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  // core response channel
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  // memory backend
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  // A zero-width counter is not legal, so the disabled-timeout build keeps one dummy bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_nx;

  // Latched request attributes needed to post-process the load data.
  logic [1:0]         size_q;
  logic               uns_q;
  logic [OFF_W-1:0]   off_q;
  logic [CNT_W-1:0]   cnt;

  // Request-side decode (valid only while accepting in IDLE).
  logic               accept;
  logic               acc_bad;
  logic [3:0]         nbytes_in;
  logic [NB-1:0]      wmask_base;
  logic [NB-1:0]      wmask_in;
  logic [DATA_W-1:0]  wdata_in;

  // Response-side decode.
  logic [CNT_W-1:0]   cnt_inc;
  logic               tmo_hit;
  logic [7:0]         nbits;
  logic [DATA_W-1:0]  lane;
  logic [DATA_W-1:0]  keep;
  logic [DATA_W-1:0]  msb;
  logic               sign;
  logic [DATA_W-1:0]  ld_data;

  // Handshake outputs come straight from the state register.
  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign resp_valid    = (state == RESP);

  assign accept  = (state == IDLE) && req_valid;
  assign cnt_inc = cnt + 1'b1;
  assign tmo_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // Alignment/size check, byte-lane shift of store data and byte-enable generation.
  always_comb begin
    nbytes_in  = 4'd1 << req_size;
    wmask_base = '0;
    for (int i = 0; i < NB; i++) begin
      wmask_base[i] = (i < int'(nbytes_in));
    end
    wmask_in = wmask_base << req_addr[OFF_W-1:0];
    wdata_in = req_wdata << {req_addr[OFF_W-1:0], 3'b000};
    acc_bad  = ((DATA_W == 32) && (req_size == 2'd3)) ||
               (({{(4-OFF_W){1'b0}}, req_addr[OFF_W-1:0]} & (nbytes_in - 4'd1)) != 4'd0);
  end

  // Load lane extraction and sign/zero extension; keep masks the access bytes, msb isolates its top bit.
  always_comb begin
    nbits   = 8'd8 << size_q;
    lane    = mem_rdata >> {off_q, 3'b000};
    keep    = ~({DATA_W{1'b1}} << nbits);
    msb     = keep ^ (keep >> 1);
    sign    = (|(lane & msb)) && !uns_q;
    ld_data = (lane & keep) | (sign ? ~keep : '0);
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a response in the same cycle as the timeout takes priority.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid)     state_nx = acc_bad ? RESP : REQ;
      REQ:  if (mem_req_ready) state_nx = WAIT;
      WAIT: if (mem_resp_valid || tmo_hit) state_nx = RESP;
      RESP: if (resp_ready)    state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Request latch and backend request fields; held untouched outside IDLE acceptance.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (accept) begin
      size_q    <= req_size;
      uns_q     <= req_unsigned;
      off_q     <= req_addr[OFF_W-1:0];
      mem_wen   <= req_wen;
      mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      mem_wdata <= req_wen ? wdata_in : '0;
      mem_wmask <= req_wen ? wmask_in : '0;
    end
  end

  // Response payload: error on bad request or timeout, load data on backend response.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_rdata <= '0;
      resp_err   <= acc_bad;
    end else if (state == WAIT) begin
      if (mem_resp_valid) begin
        resp_rdata <= mem_wen ? '0 : ld_data;
        resp_err   <= 1'b0;
      end else if (tmo_hit) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

  // WAIT cycle counter: cleared on the backend handshake, counts every WAIT cycle.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt <= '0;
    end else if (state == REQ && mem_req_ready) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
- Handshaked, multi-cycle load/store unit. It is the parametrised successor to the single-cycle LSU path between the decode/execute stages and data memory.
- Accepts one request from the core over a valid/ready channel and checks alignment.
- Issues the access to a memory backend over a valid/ready request plus response-valid channel.
- Returns a sign- or zero-extended load result, or a write completion, over a valid/ready response channel.
- Width, backend timeout and extension behaviour are parametrised; misalignment and timeout errors are reported to the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data bus width. Legal values: 32 or 64. OFF_W = log2(DATA_W/8).
- TIMEOUT, 0, maximum cycles spent in WAIT before an error response. 0 disables the timeout.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend the load result.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access, illegal size, or timeout.
- mem_req_valid  out  1  backend request valid.
- mem_req_ready  in  1  backend accepts the request.
- mem_wen  out  1  backend write.
- mem_addr  out  ADDR_W  address with the low OFF_W bits forced to 0.
- mem_wdata  out  DATA_W  store data shifted to its byte lane.
- mem_wmask  out  DATA_W/8  byte enables; 0 for loads.
- mem_resp_valid  in  1  backend response or write acknowledge.
- mem_rdata  in  DATA_W  backend read data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0 except req_ready = 1. Reset asserted in any state aborts the access, drops any pending response, clears the timeout counter and returns to IDLE.
- Outputs are registered and decoded from state:
  - req_ready = 1 only in IDLE.
  - mem_req_valid = 1 only in REQ.
  - resp_valid = 1 only in RESP.
- IDLE: on req_valid & req_ready, latch the request.
  - If size is illegal (size 3 with DATA_W = 32), or the address is misaligned (addr mod 2^size != 0): go to RESP with resp_err = 1 and resp_rdata = 0. No backend request is made; resp_valid rises one cycle after acceptance.
  - Otherwise: go to REQ; mem_req_valid rises one cycle after acceptance.
- REQ:
  - Hold mem_addr, mem_wen, mem_wdata and mem_wmask stable until mem_req_ready.
  - mem_wdata = req_wdata << (8 * offset).
  - mem_wmask = ((1 << 2^size) - 1) << offset for stores; 0 for loads.
  - On mem_req_ready, go to WAIT.
  - mem_req_valid never drops before mem_req_ready.
- WAIT:
  - mem_resp_valid is sampled only in WAIT; it is ignored in all other states.
  - On mem_resp_valid, go to RESP next cycle with resp_err = 0.
  - Load result: take the lane (mem_rdata >> 8*offset) truncated to 2^size bytes, then sign-extend (req_unsigned = 0) or zero-extend (req_unsigned = 1) to DATA_W.
  - Store result: resp_rdata = 0.
- Timeout (TIMEOUT > 0):
  - The counter clears on entry to WAIT and increments each cycle in WAIT.
  - When the count reaches TIMEOUT without mem_resp_valid, go to RESP with resp_err = 1 and resp_rdata = 0.
  - If mem_resp_valid arrives in the same cycle the count reaches TIMEOUT, the response wins.
  - Counter width is clog2(TIMEOUT+1).
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready, then go to IDLE.
  - No new request is accepted in the cycle resp_ready is seen; req_ready rises the following cycle.
- Minimum load latency from acceptance to resp_valid is 3 cycles, when mem_req_ready = 1 and mem_resp_valid arrives the cycle after the backend handshake.
- Byte order is little-endian; the byte lane index equals addr[OFF_W-1:0].

Test Plan:
- Load extension, DATA_W = 32, backend word 0x8899AABB at 0x80000000:
  - lb at 0x80000001 -> resp_rdata 0xFFFFFFAA, mem_addr 0x80000000.
  - lbu at 0x80000001 -> 0x000000AA.
  - lh at 0x80000002 -> 0xFFFF8899.
- sh at 0x80000002, wdata 0x00001234 -> mem_wdata 0x12340000, mem_wmask 0b1100, mem_wen 1; resp_rdata 0, resp_err 0.
- Misaligned lw at 0x80000002 -> resp_valid at acceptance+1 with resp_err 1; mem_req_valid stays 0 throughout.
- Backpressure: mem_req_ready low for 3 cycles, then resp_ready low for 4 cycles -> mem_* and resp_* held stable, req_ready 0 throughout; 1 cycle after resp_ready, req_ready = 1.
- TIMEOUT = 4, backend never responds -> resp_valid with resp_err 1 exactly 4 cycles after WAIT entry. A repeat with mem_resp_valid on the 4th cycle -> resp_err 0 with data.
- DATA_W = 64: ld at 0x8 with mem_rdata 0xF0E0D0C0B0A09080 -> same value. ld at 0x4 -> resp_err 1.
- Reset asserted low while in WAIT -> all outputs return to reset values immediately. The next request then completes normally.
